// File: rtl/rr_arbiter_16_pkg.sv
// rr_arbiter_16_pkg
//   Shared sizing constants and the arbiter state type for the 16-way
//   round-robin arbiter and its grant decoder.
//   No ports; imported by rr_arbiter_16 and dec_4to16.
package rr_arbiter_16_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;
  localparam int HOLD_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter_16_dec.sv
// dec_4to16
//   4-to-16 one-hot decoder with enable. Output is all zero when E is low.
//   Ports:
//     A  input  [3:0]   index to decode
//     E  input          enable
//     D  output [15:0]  one-hot decode of A, gated by E
module dec_4to16
  import rr_arbiter_16_pkg::*;
(
  input  logic [IDX_W-1:0]   A,
  input  logic               E,
  output logic [NUM_REQ-1:0] D
);

  always_comb begin
    D = '0;
    if (E) begin
      D[A] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16
//   Round-robin arbiter sharing one resource among 16 requesters. A winner is
//   picked circularly starting at ptr, held until the requester drops its
//   request or MAX_HOLD busy cycles elapse, and priority then moves to the
//   requester just after the winner.
//   Parameters:
//     MAX_HOLD   maximum consecutive busy cycles per grant (0 = unlimited,
//                legal range 0..255)
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     en         allows new grants when high; an active grant is unaffected
//     req        request vector, one bit per requester
//     gnt        one-hot grant decoded from gnt_idx, zero when not valid
//     gnt_idx    registered index of the current grantee
//     gnt_valid  registered grant-active flag
//     timeout    one-cycle pulse following a forced release
module rr_arbiter_16
  import rr_arbiter_16_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  // With MAX_HOLD = 0 the limit is disabled, so the compare value is
  // irrelevant and just needs to be a legal constant.
  localparam bit                HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_e          state, state_n;
  logic [IDX_W-1:0]    ptr, ptr_n;
  logic [IDX_W-1:0]    idx_n;
  logic                valid_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic                timeout_n;
  logic [IDX_W-1:0]    winner;
  logic                cur_req;
  logic                forced;

  // Circular priority search: rotate the requests so ptr lands at bit 0,
  // take the lowest set bit, then add ptr back (wrapping in 4 bits).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;
    dbl = {r, r} >> p;
    rot = dbl[NUM_REQ-1:0];
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = i[IDX_W-1:0];
      end
    end
    return off + p;
  endfunction

  assign winner  = rr_pick(req, ptr);
  assign cur_req = req[gnt_idx];
  assign forced  = HOLD_EN && (hold_cnt == HOLD_LAST) && cur_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gnt_idx   <= idx_n;
      gnt_valid <= valid_n;
      hold_cnt  <= hold_n;
      timeout   <= timeout_n;
    end
  end

  // Every release passes through IDLE, which guarantees at least one
  // no-grant cycle between grants, even a re-grant to the same requester.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    idx_n     = gnt_idx;
    valid_n   = gnt_valid;
    hold_n    = hold_cnt;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        if (en && (|req)) begin
          idx_n   = winner;
          valid_n = 1'b1;
          hold_n  = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (!cur_req || forced) begin
          valid_n   = 1'b0;
          ptr_n     = gnt_idx + 1'b1;
          state_n   = IDLE;
          timeout_n = forced;
        end else if (hold_cnt != '1) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  dec_4to16 u_dec (
    .A (gnt_idx),
    .E (gnt_valid),
    .D (gnt)
  );

endmodule
